// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator paced by a pixel clock enable on Clk.
// Produces registered sync, pixel coordinates, line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          en,
  output logic          pixel_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // Window tests are done at int width so a sync pulse ending at H_TOTAL cannot overflow CW.
  function automatic logic in_window(input logic [CW-1:0] c, input int lo, input int hi);
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < hi);
  endfunction

  function automatic logic hs_level(input logic [CW-1:0] x);
    return in_window(x, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic vs_level(input logic [CW-1:0] y);
    return in_window(y, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
  endfunction

  logic [DW-1:0] div;
  logic          wrap;
  logic          h_end;
  logic          v_end;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;

  always_comb begin
    wrap  = (div == DIV_LAST);
    h_end = (DrawX == H_LAST);
    v_end = (DrawY == V_LAST);
    x_nxt = h_end ? '0 : DrawX + 1'b1;
    y_nxt = DrawY;
    if (h_end) begin
      y_nxt = v_end ? '0 : DrawY + 1'b1;
    end
  end

  // Counters and sync are updated together so hs/vs always describe the current DrawX/DrawY.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div         <= '0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      pixel_ce    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (!en) begin
      div         <= '0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      pixel_ce    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= wrap ? '0 : div + 1'b1;
      pixel_ce    <= wrap;
      line_start  <= wrap && (x_nxt == '0);
      frame_start <= wrap && (x_nxt == '0) && (y_nxt == '0);
      if (wrap) begin
        DrawX <= x_nxt;
        DrawY <= y_nxt;
        hs    <= hs_level(x_nxt);
        vs    <= vs_level(y_nxt);
        if (h_end && v_end) begin
          frame_count <= frame_count + 1'b1;
        end
      end
    end
  end

  assign blank = (int'(DrawX) < H_ACTIVE) && (int'(DrawY) < V_ACTIVE);
  assign sync  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster (14x7 totals, 3 Clks per pixel, 2-bit frame counter).
module tb_vga_timing_gen;

  localparam int D  = 3;
  localparam int HT = 14;
  localparam int VT = 7;

  typedef struct packed {
    logic       ce;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       ls;
    logic       fs;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] fc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       pixel_ce, hs, vs, blank, sync, line_start, frame_start;
  logic [3:0] DrawX, DrawY;
  logic [1:0] frame_count;

  obs_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  int   fb = 0;
  int   cyc = 0;

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(4), .FW(2)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .en(en), .pixel_ce(pixel_ce), .hs(hs), .vs(vs),
    .blank(blank), .sync(sync), .DrawX(DrawX), .DrawY(DrawY),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Closed-form expectation from Clk edges since release (tt) and frames completed before the last restart (fbase).
  function automatic obs_t model(input int tt, input int fbase);
    obs_t e;
    int p, x, y;
    p = tt / D;
    x = p % HT;
    y = (p / HT) % VT;
    e.ce    = (tt > 0) && (tt % D == 0);
    e.x     = 4'(x);
    e.y     = 4'(y);
    e.hs    = (x >= 10 && x < 12) ? 1'b0 : 1'b1;
    e.vs    = (y == 5) ? 1'b1 : 1'b0;
    e.blank = (x < 8) && (y < 4);
    e.sync  = 1'b0;
    e.ls    = e.ce && (x == 0);
    e.fs    = e.ce && (x == 0) && (y == 0);
    e.fc    = 2'((fbase + p / (HT * VT)) % 4);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      t  = 0;
      fb = 0;
    end else if (!en) begin
      fb = fb + (t / D) / (HT * VT);
      t  = 0;
    end else begin
      t++;
    end
    #1;
    q.push_back(model(t, fb));
  endtask

  // Reset_n falls between clock edges; outputs must already be at reset values by the next sample.
  task automatic async_reset();
    @(posedge clk);
    cyc++;
    #3;
    rst_n = 1'b0;
    t  = 0;
    fb = 0;
    q.push_back(model(0, 0));
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{ce: pixel_ce, hs: hs, vs: vs, blank: blank, sync: sync, ls: line_start,
            fs: frame_start, x: DrawX, y: DrawY, fc: frame_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle%0d: got ce=%b hs=%b vs=%b blank=%b sync=%b ls=%b fs=%b x=%0d y=%0d fc=%0d; want ce=%b hs=%b vs=%b blank=%b sync=%b ls=%b fs=%b x=%0d y=%0d fc=%0d",
                 cyc, a.ce, a.hs, a.vs, a.blank, a.sync, a.ls, a.fs, a.x, a.y, a.fc,
                 e.ce, e.hs, e.vs, e.blank, e.sync, e.ls, e.fs, e.x, e.y, e.fc);
      end
    end
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (1000) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (700) step();
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (400) step();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
